conv_mac_accumulator: RTL and testbench
=======================================

Name: conv_mac_accumulator

Overview:
- Downstream stage of the signed 8x8 multiplier in the convolution datapath.
- Consumes a stream of signed 16-bit products and sums TAPS consecutive products into one kernel-window result.
- Rounds and shifts the sum right by SHIFT, saturates it to OUT_W bits, and presents it on a valid/ready output register for the next layer or writeback.

Parameters:
- TAPS, 9, products per window (kernel size, e.g. 3x3); legal range 1 to 256.
- ACC_W, 24, accumulator width; must be at least 16 + clog2(TAPS), otherwise elaboration fails.
- SHIFT, 0, arithmetic right-shift applied to the final sum; legal range 0 to ACC_W-1.
- OUT_W, 16, output width; legal range 2 to ACC_W.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of the partial window.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a product.
- in_product  in  16  signed product from the multiplier.
- out_valid  out  1  window result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  OUT_W  signed window result after rounding and saturation.
- out_sat  out  1  out_data was clamped; qualified by out_valid.
- busy  out  1  a partial window is in progress (count != 0).

Behaviour:
- Reset (rst_n low, asynchronous): acc=0, count=0, out_valid=0, out_data=0, out_sat=0. busy=0 follows from count=0.
- in_ready = !clear && (!out_valid || out_ready). This is combinational; there is no path from in_valid to in_ready.
- Accept: a beat is accepted when in_valid && in_ready.
  - in_product is sign-extended to ACC_W.
  - sum = (count==0) ? ext : acc + ext.
- Non-final beat (count < TAPS-1): acc <= sum, count <= count+1.
- Final beat (count == TAPS-1): count <= 0, acc <= 0, out_valid <= 1, out_data/out_sat loaded from sum in the same edge. Window latency is 1 cycle from the final beat to out_valid.
- TAPS=1: every accepted beat is a final beat.
- Rounding (SHIFT>0): r = (sum + 2^(SHIFT-1)) >>> SHIFT. This is round-half-up toward +inf. It is computed with one guard bit, so the add never wraps.
- No rounding (SHIFT=0): r = sum.
- Saturation: if r > 2^(OUT_W-1)-1, out_data = max and out_sat=1. If r < -2^(OUT_W-1), out_data = min and out_sat=1. Otherwise out_data = r and out_sat=0.
- Output handshake:
  - out_data and out_sat are stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new final beat lands the same cycle. In that case it stays 1 with the new data, giving back-to-back windows at full rate.
- Backpressure: while out_valid && !out_ready, in_ready=0. The partial window of the next result is frozen (acc and count hold).
- clear:
  - On the next edge, count<=0 and acc<=0. in_ready=0 that cycle, so no beat is consumed.
  - A pending result (out_valid=1) is preserved and still handshakes normally.
  - clear with count==0 has no effect.
- Simultaneous out_ready and final beat: the old result retires and the new one loads in the same edge.
- Reset mid-window or mid-handshake: everything returns to reset values immediately. The partial window and any pending result are lost.
- No internal FSM beyond the implicit two phases (accumulating / holding result). Invalid states are impossible: count only reaches 0..TAPS-1.

Test Plan:
- Basic window: TAPS=9, SHIFT=0, products 1..9 back-to-back, out_ready=1 -> one cycle after beat 9, out_valid=1, out_data=45, out_sat=0, busy=0.
- Negative saturation: TAPS=9, nine beats of -16129 (-127*127) -> sum -145161 -> out_data=-32768, out_sat=1. Repeat with +16384 x9 -> out_data=32767, out_sat=1.
- Rounding: SHIFT=4, TAPS=1, product 24 -> out_data=2; product -24 -> -1; product 8 -> 1; product -8 -> 0.
- Backpressure: two windows streamed with out_ready=0 after first result -> in_ready=0, first result (45) held stable for 5 cycles. Raise out_ready -> 45 retires, second window resumes with no lost or duplicated beats. Then verify back-to-back full-rate with out_ready=1: results every 9 cycles.
- clear mid-window: 4 beats of 100, clear pulse, then 9 beats of 1 -> out_data=9. Also clear while a result is pending -> pending result still delivered unchanged.
- Async reset: deassert rst_n mid-window (count=5) and separately while out_valid=1 -> outputs zero without a clock edge. After release, a fresh 9-beat window of 2 -> out_data=18.

Source files
------------

// File: rtl/conv_mac_accumulator.sv
// Window accumulator behind the signed 8x8 multiplier: sums TAPS signed products,
// rounds/shifts by SHIFT, saturates to OUT_W bits and holds the result on a
// valid/ready output register.
module conv_mac_accumulator #(
  parameter int unsigned TAPS  = 9,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             busy
);

  localparam int unsigned CntW = (TAPS > 1) ? $clog2(TAPS) : 1;

  // Saturation bounds in the guarded (ACC_W+1)-bit domain.
  localparam logic signed [ACC_W:0] SatMax = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SatMin = ~SatMax;

  if (TAPS < 1 || TAPS > 256) begin : gen_taps_check
    $error("TAPS must be in 1..256");
  end
  if (ACC_W < 16 + $clog2(TAPS)) begin : gen_acc_w_check
    $error("ACC_W must be at least 16 + clog2(TAPS)");
  end
  if (OUT_W < 2 || OUT_W > ACC_W || SHIFT >= ACC_W) begin : gen_width_check
    $error("OUT_W must be in 2..ACC_W and SHIFT below ACC_W");
  end

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0] ext, sum;
  logic signed [ACC_W:0]   sum_g, rnd;
  logic                    accept, last_beat, sat_hi, sat_lo;

  assign in_ready  = !clear && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign ext       = ACC_W'($signed(in_product));
  assign sum       = (count_q == '0) ? ext : acc_q + ext;
  assign last_beat = (count_q == CntW'(TAPS - 1));

  // One guard bit so the rounding add cannot wrap.
  assign sum_g = {sum[ACC_W-1], sum};

  if (SHIFT > 0) begin : gen_round
    localparam logic signed [ACC_W:0] Half = (ACC_W + 1)'(1) << (SHIFT - 1);
    assign rnd = (sum_g + Half) >>> SHIFT;
  end else begin : gen_no_round
    assign rnd = sum_g;
  end

  assign sat_hi = (rnd > SatMax);
  assign sat_lo = (rnd < SatMin);

  // Next-state: accumulate, flush on clear, load the output register on the final beat.
  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (clear) begin
      acc_d   = '0;
      count_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        acc_d       = '0;
        count_d     = '0;
        out_valid_d = 1'b1;
        out_sat_d   = sat_hi || sat_lo;
        if (sat_hi) begin
          out_data_d = SatMax[OUT_W-1:0];
        end else if (sat_lo) begin
          out_data_d = SatMin[OUT_W-1:0];
        end else begin
          out_data_d = rnd[OUT_W-1:0];
        end
      end else begin
        acc_d   = sum;
        count_d = count_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = (count_q != '0);

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Bench for conv_mac_accumulator: 9-tap unshifted instance with a result scoreboard,
// plus a 1-tap SHIFT=4 / OUT_W=8 instance for rounding and saturation vectors.
module tb_conv_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_product = '0;
  logic        in_ready, out_valid, out_sat, busy;
  logic [15:0] out_data;

  logic        r_clear = 1'b0;
  logic        r_in_valid = 1'b0;
  logic        r_out_ready = 1'b1;
  logic [15:0] r_in_product = '0;
  logic        r_in_ready, r_out_valid, r_out_sat, r_busy;
  logic [7:0]  r_out_data;

  conv_mac_accumulator #(.TAPS(9), .ACC_W(24), .SHIFT(0), .OUT_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  conv_mac_accumulator #(.TAPS(1), .ACC_W(16), .SHIFT(4), .OUT_W(8)) u_rnd (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (r_clear),
    .in_valid   (r_in_valid),
    .in_ready   (r_in_ready),
    .in_product (r_in_product),
    .out_valid  (r_out_valid),
    .out_ready  (r_out_ready),
    .out_data   (r_out_data),
    .out_sat    (r_out_sat),
    .busy       (r_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        sat;
  } res_t;

  typedef struct {
    int prod;
    int exp_data;
    bit exp_sat;
  } vec_t;

  int     n_vec = 0;
  int     n_miss = 0;
  longint cyc = 0;
  res_t   sb[$];
  longint pop_cyc[$];
  res_t   mon_e;
  vec_t   wv[8];
  vec_t   rv[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input bit s);
    sb.push_back('{data: 16'(d), sat: s});
  endtask

  // Retire results on the handshake, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_result: got %0d, expected no result", $signed(out_data));
      end else begin
        mon_e = sb.pop_front();
        check("result_data", $signed(out_data), $signed(mon_e.data));
        check("result_sat", int'(out_sat), int'(mon_e.sat));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold one beat until it is accepted; returns just after the accepting edge.
  task automatic send_beat(input int p);
    bit took = 1'b0;
    in_valid   = 1'b1;
    in_product = 16'(p);
    for (int i = 0; i < 200 && !took; i++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    if (!took) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_beat: got in_ready=0 for 200 cycles, expected acceptance");
    end
  endtask

  task automatic send_window(input int p);
    for (int i = 0; i < 9; i++) send_beat(p);
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input int first);
    for (int i = 0; i < 9; i++) send_beat(first + i);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wv[0] = '{-16129, -32768, 1'b1};
    wv[1] = '{16384, 32767, 1'b1};
    wv[2] = '{3640, 32760, 1'b0};
    wv[3] = '{3641, 32767, 1'b1};
    wv[4] = '{-3640, -32760, 1'b0};
    wv[5] = '{-3641, -32768, 1'b1};
    wv[6] = '{0, 0, 1'b0};
    wv[7] = '{-1, -9, 1'b0};

    rv[0] = '{24, 2, 1'b0};
    rv[1] = '{-24, -1, 1'b0};
    rv[2] = '{8, 1, 1'b0};
    rv[3] = '{-8, 0, 1'b0};
    rv[4] = '{2032, 127, 1'b0};
    rv[5] = '{2040, 127, 1'b1};
    rv[6] = '{-2056, -128, 1'b0};
    rv[7] = '{-2057, -128, 1'b1};
    rv[8] = '{32767, 127, 1'b1};
    rv[9] = '{-32768, -128, 1'b1};

    // Reset state
    tick(2);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_r_out_valid", int'(r_out_valid), 0);
    rst_n = 1'b1;
    tick(1);

    // Basic window 1..9
    out_ready = 1'b1;
    push(45, 1'b0);
    send_beat(1);
    check("busy_mid_window", int'(busy), 1);
    for (int i = 2; i <= 9; i++) send_beat(i);
    in_valid = 1'b0;
    check("basic_latency_valid", int'(out_valid), 1);
    check("basic_data", $signed(out_data), 45);
    check("basic_busy", int'(busy), 0);
    tick(1);
    check("basic_retired", int'(out_valid), 0);
    drain();

    // Constant-product windows, back to back
    for (int v = 0; v < 8; v++) begin
      push(wv[v].exp_data, wv[v].exp_sat);
      send_window(wv[v].prod);
    end
    drain();

    // Backpressure: first result held while the next window waits
    out_ready = 1'b0;
    push(45, 1'b0);
    send_seq(1);
    in_product = 16'd10;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_valid_held", int'(out_valid), 1);
      check("bp_data_held", $signed(out_data), 45);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_busy_frozen", int'(busy), 0);
    end
    out_ready = 1'b1;
    push(126, 1'b0);
    send_seq(10);
    in_valid = 1'b0;
    drain();

    // Full-rate back-to-back windows
    pop_cyc.delete();
    for (int w = 2; w <= 4; w++) begin
      push(9 * w, 1'b0);
      send_window(w);
    end
    drain();
    check("b2b_count", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      for (int i = 1; i < 3; i++) check("b2b_interval", int'(pop_cyc[i] - pop_cyc[i-1]), 9);
    end

    // clear mid-window
    for (int i = 0; i < 4; i++) send_beat(100);
    in_valid = 1'b0;
    check("clr_busy_before", int'(busy), 1);
    clear = 1'b1;
    #1;
    check("clr_in_ready", int'(in_ready), 0);
    tick(1);
    clear = 1'b0;
    check("clr_busy_after", int'(busy), 0);
    push(9, 1'b0);
    send_window(1);
    drain();

    // clear while a result is pending
    out_ready = 1'b0;
    push(18, 1'b0);
    send_window(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    check("clr_pend_valid", int'(out_valid), 1);
    check("clr_pend_data", $signed(out_data), 18);
    out_ready = 1'b1;
    drain();

    // Async reset mid-window
    for (int i = 0; i < 5; i++) send_beat(2);
    in_valid = 1'b0;
    check("arst_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(out_valid), 0);
    #2 rst_n = 1'b1;
    tick(1);

    // Async reset while a saturated result is pending (result is discarded)
    out_ready = 1'b0;
    send_window(16384);
    check("arst2_valid_before", int'(out_valid), 1);
    check("arst2_sat_before", int'(out_sat), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst2_valid", int'(out_valid), 0);
    check("arst2_data", int'(out_data), 0);
    check("arst2_sat", int'(out_sat), 0);
    #2 rst_n = 1'b1;
    tick(1);
    out_ready = 1'b1;
    push(18, 1'b0);
    send_window(2);
    drain();

    // Rounding and saturation on the single-tap instance
    for (int v = 0; v < 10; v++) begin
      check("rnd_in_ready", int'(r_in_ready), 1);
      r_in_valid   = 1'b1;
      r_in_product = 16'(rv[v].prod);
      tick(1);
      r_in_valid = 1'b0;
      check("rnd_valid", int'(r_out_valid), 1);
      check("rnd_data", $signed(r_out_data), rv[v].exp_data);
      check("rnd_sat", int'(r_out_sat), int'(rv[v].exp_sat));
      check("rnd_busy", int'(r_busy), 0);
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
